pipeline_controller: RTL
========================

# pipeline_controller

Central stall/flush sequencer for the 5-stage pipelined RISC-V core. Sits beside the decode-stage control unit and drives the pipeline-register enables and bubbles. Three jobs:
- sequences multi-cycle data-memory accesses (LD/SW/SD) with a req/ready handshake and a timeout;
- detects load-use hazards;
- flushes the front end on taken branches.

It also keeps saturating performance counters.

## Interface
- `TIMEOUT`, default 255: maximum wait cycles (after the first request cycle) for `dmem_ready` before declaring a memory error; must be ≥1.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `id_rs1`, `id_rs2` input 5: source registers of the instruction in ID.
- `id_uses_rs2` input 1: the ID instruction reads rs2 (R-type, S-type, B-type).
- `ex_mem_read` input 1: the instruction in EX is a load.
- `ex_rd` input 5: destination register of the instruction in EX.
- `ex_branch_taken` input 1: the branch in EX resolved taken.
- `mem_mem_read`, `mem_mem_write` input 1: the instruction in MEM is a load or store.
- `dmem_ready` input 1: data memory has completed the current access this cycle.
- `dmem_req` output 1: data memory access request, held until ready.
- `pc_stall` output 1: hold the PC.
- `if_id_stall` output 1: hold IF/ID.
- `id_ex_stall` output 1: hold ID/EX.
- `ex_mem_stall` output 1: hold EX/MEM.
- `if_id_flush` output 1: load NOP into IF/ID.
- `id_ex_flush` output 1: load a bubble into ID/EX (all control bits 0).
- `mem_wb_bubble` output 1: load a bubble into MEM/WB.
- `mem_error` output 1: sticky memory timeout flag.
- `stall_cycles` output `CNT_W`: count of cycles with `pc_stall`=1.
- `flush_count` output `CNT_W`: count of taken-branch flushes.

## Operation
- The FSM has three states: RUN, WAIT, ERROR. The wait counter `wait_cnt` is `$clog2(TIMEOUT+1)` bits.
- `mem_acc` = `mem_mem_read` | `mem_mem_write`.

RUN:
- `dmem_req` = `mem_acc`.
- If `mem_acc` & !`dmem_ready`:
  - assert a memory stall this cycle;
  - next state is WAIT with `wait_cnt`=1.
- If `mem_acc` & `dmem_ready`: the access completes with zero wait and there is no stall.

WAIT:
- `dmem_req`=1 and a memory stall is asserted.
- If `dmem_ready`=1: the stall drops this cycle, the pipeline advances, and the next state is RUN.
- Else if `wait_cnt`==`TIMEOUT`: next state is ERROR.
- Else: `wait_cnt`+1.

ERROR:
- Memory stall is asserted permanently, `dmem_req`=0, and `mem_error`=1.
- Only `rst` exits this state.

Memory stall asserts `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_bubble`. No flushes are asserted during a memory stall.

When no memory stall is active, the following apply in priority order:
1. Taken branch (`ex_branch_taken`): assert `if_id_flush` and `id_ex_flush`; no PC stall.
2. Load-use: `ex_mem_read` & `ex_rd`≠0 & (`ex_rd`==`id_rs1` | (`id_uses_rs2` & `ex_rd`==`id_rs2`)). Assert `pc_stall`, `if_id_stall` and `id_ex_flush` for exactly one cycle.
   - A branch and a load-use hazard in the same cycle resolve as branch only, because the ID instruction is being discarded.
   - A branch or load-use condition present during a memory stall is not lost. EX/ID are frozen, so the condition is re-evaluated on the release cycle.

Counters:
- `stall_cycles` increments on every cycle with `pc_stall`=1, including memory, load-use and ERROR cycles.
- `flush_count` increments on every cycle a branch flush is asserted.
- Both saturate at all-ones.

## Timing
- The FSM, `wait_cnt`, `mem_error` and counters are registered. All stall, flush and `dmem_req` outputs are combinational from state and inputs.
- While `rst`=1:
  - all stall, flush, bubble and `dmem_req` outputs are forced to 0;
  - on the next edge: state=RUN, `wait_cnt`=0, `mem_error`=0, `stall_cycles`=0, `flush_count`=0.
- A reset during WAIT or ERROR drops `dmem_req` in the reset cycle. The MEM instruction is abandoned; the pipeline reset is responsible for that.
- Latency:
  - zero-wait access: 0 stall cycles;
  - ready N cycles after the first request: N stall cycles, with `dmem_req` high for N+1 cycles.
- Timeout: with `dmem_ready` held low, `dmem_req` stays high for `TIMEOUT`+1 cycles. `mem_error` rises on the cycle after that.
- `dmem_ready` arriving in the same cycle that `wait_cnt`==`TIMEOUT` counts as a completion (RUN, no error).
- Back-to-back memory instructions: the cycle that completes one access may present the next access in MEM on the following cycle. The FSM then re-enters its RUN evaluation fresh.
- `dmem_ready` while `dmem_req`=0 is ignored.

## Test plan
- Reset with all inputs at 1 → all outputs 0 in the reset cycle. After release with inputs at 0, counters are 0 and `mem_error`=0.
- LD in MEM with `dmem_ready` after 3 cycles → `dmem_req` high for 4 cycles, the four stall outputs plus `mem_wb_bubble` high for 3 cycles, then FSM in RUN and `stall_cycles`=3.
- `TIMEOUT`=4, store in MEM, `dmem_ready` tied low → `dmem_req` high for 5 cycles, `mem_error`=1 from cycle 5 and stays 1 with all stalls held. Asserting `rst` then clears everything.
- `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 → `pc_stall`/`if_id_stall`/`id_ex_flush` for one cycle. Repeating with `ex_rd`=0 or `id_uses_rs2`=0 (and `id_rs1`≠5) → no stall.
- `ex_branch_taken`=1 together with a load-use match → only `if_id_flush`+`id_ex_flush`, `pc_stall`=0, `flush_count`+1.
- `ex_branch_taken`=1 during a 2-cycle memory wait → no flush while stalled. The flush is asserted on the release cycle and `flush_count` increments once.

Source files
------------

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush sequencer for memory waits, load-use hazards and taken branches
module pipeline_controller #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERROR} state_t;
    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             err_q;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             mem_acc, mem_stall, req, load_use, branch;
    assign mem_acc  = mem_mem_read | mem_mem_write;
    assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                      (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    assign branch   = ex_branch_taken;
    // Memory-access FSM: next state, wait counter, raw stall and request
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_stall = 1'b0;
        req       = 1'b0;
        case (state_q)
            S_RUN: begin
                req = mem_acc;
                if (mem_acc && !dmem_ready) begin
                    mem_stall = 1'b1;
                    state_d   = S_WAIT;
                    wait_d    = WW'(1);
                end
            end
            S_WAIT: begin
                req       = 1'b1;
                mem_stall = !dmem_ready;
                if (dmem_ready) begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end else if (wait_q == WW'(TIMEOUT)) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: mem_stall = 1'b1;
        endcase
    end
    // Pipeline controls; a memory stall masks branch and load-use, which re-evaluate on release
    always_comb begin
        dmem_req      = !rst && req;
        pc_stall      = !rst && (mem_stall || (!branch && load_use));
        if_id_stall   = pc_stall;
        id_ex_stall   = !rst && mem_stall;
        ex_mem_stall  = id_ex_stall;
        mem_wb_bubble = id_ex_stall;
        if_id_flush   = !rst && !mem_stall && branch;
        id_ex_flush   = !rst && !mem_stall && (branch || load_use);
    end
    // State, sticky error flag and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_q || state_d == S_ERROR;
            stall_q <= (pc_stall && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
            flush_q <= (if_id_flush && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
        end
    end
    assign mem_error    = err_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
endmodule
